// File: rtl/internet_pkg.sv
// Shared definitions for the internet routing mux/demux pair.
// Endpoint select codes and the arbiter FSM state type.
package internet_pkg;

   localparam logic [1:0] SEL_LIB    = 2'b00;
   localparam logic [1:0] SEL_FD     = 2'b01;
   localparam logic [1:0] SEL_RIBS   = 2'b10;
   localparam logic [1:0] SEL_SCHOOL = 2'b11;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

endpackage

// File: rtl/internet_mux_arbiter_if.sv
// Endpoint-side data/request bundle plus the shared link outputs.
// The arbiter uses the master view; the endpoints and the link use the slave view.
interface internet_mux_arbiter_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] LibIn;
   logic [WIDTH-1:0] FDIn;
   logic [WIDTH-1:0] RibsIn;
   logic [WIDTH-1:0] SchoolIn;
   logic [3:0]       req;
   logic             linkReady;
   logic [3:0]       grant;
   logic [WIDTH-1:0] muxOutput;
   logic [1:0]       Sel;
   logic             Enable;

   modport master (
      input  LibIn, FDIn, RibsIn, SchoolIn, req, linkReady,
      output grant, muxOutput, Sel, Enable
   );

   modport slave (
      output LibIn, FDIn, RibsIn, SchoolIn, req, linkReady,
      input  grant, muxOutput, Sel, Enable
   );

endinterface

// File: rtl/internet_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req from last+1 upward, wrapping,
// so the previous owner is considered last.
module rr_pick (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic       any,
   output logic [1:0] win
);

   logic [1:0] candidate;

   // Walk from the lowest priority (last itself) to the highest so the nearest hit wins.
   always_comb begin
      any       = 1'b0;
      win       = last;
      candidate = last;
      for (int i = 4; i >= 1; i--) begin
         candidate = last + 2'(i);
         if (req[candidate]) begin
            any = 1'b1;
            win = candidate;
         end
      end
   end

endmodule

// File: rtl/internet_mux_arbiter.sv
// Round-robin arbiter merging four endpoints onto one flow-controlled link,
// with each owner's tenure capped at HOLD_CYCLES accepted beats.
module internet_mux_arbiter
   import internet_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   internet_mux_arbiter_if.master link
);

   state_t           state, state_next;
   logic [1:0]       owner, owner_next;
   logic [1:0]       last, last_next;
   logic [3:0]       cnt, cnt_next;
   logic [1:0]       sel_q, sel_next;
   logic             enable_q, enable_next;
   logic [WIDTH-1:0] data_q, data_next;

   logic [WIDTH-1:0] endpoints [4];
   logic [1:0]       pick_last;
   logic             pick_any;
   logic [1:0]       pick_win;
   logic             keep_owner;

   assign endpoints[0] = link.LibIn;
   assign endpoints[1] = link.FDIn;
   assign endpoints[2] = link.RibsIn;
   assign endpoints[3] = link.SchoolIn;

   // On release the current owner becomes the lowest priority before last is updated.
   assign pick_last = (state == GRANT) ? owner : last;

   rr_pick u_pick (
      .req  (link.req),
      .last (pick_last),
      .any  (pick_any),
      .win  (pick_win)
   );

   assign keep_owner = link.req[owner] &&
                       ((5'({1'b0, cnt}) + 5'd1) < 5'(HOLD_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= SEL_LIB;
         last     <= SEL_SCHOOL;
         cnt      <= '0;
         sel_q    <= SEL_LIB;
         enable_q <= 1'b0;
         data_q   <= '0;
      end else begin
         state    <= state_next;
         owner    <= owner_next;
         last     <= last_next;
         cnt      <= cnt_next;
         sel_q    <= sel_next;
         enable_q <= enable_next;
         data_q   <= data_next;
      end
   end

   // A stalled beat (GRANT without linkReady) falls through to the hold defaults.
   always_comb begin
      state_next  = state;
      owner_next  = owner;
      last_next   = last;
      cnt_next    = cnt;
      sel_next    = sel_q;
      enable_next = enable_q;
      data_next   = data_q;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_next  = GRANT;
               owner_next  = pick_win;
               sel_next    = pick_win;
               enable_next = 1'b1;
               data_next   = endpoints[pick_win];
               cnt_next    = '0;
            end else begin
               enable_next = 1'b0;
               data_next   = '0;
            end
         end
         GRANT: begin
            if (link.linkReady) begin
               if (keep_owner) begin
                  cnt_next  = cnt + 4'd1;
                  data_next = endpoints[owner];
               end else begin
                  last_next = owner;
                  if (pick_any) begin
                     owner_next  = pick_win;
                     sel_next    = pick_win;
                     enable_next = 1'b1;
                     data_next   = endpoints[pick_win];
                     cnt_next    = '0;
                  end else begin
                     state_next  = IDLE;
                     enable_next = 1'b0;
                     data_next   = '0;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign link.Sel       = sel_q;
   assign link.Enable    = enable_q;
   assign link.muxOutput = data_q;
   assign link.grant     = (enable_q & link.linkReady) ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: tb/tb_internet_mux_arbiter.sv
// Directed bench for internet_mux_arbiter: a HOLD_CYCLES=4 instance for most
// scenarios and a HOLD_CYCLES=1 instance for forced per-beat release.
module tb_internet_mux_arbiter;
   import internet_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checkCount = 0;
   int   passCount  = 0;

   always #5 clk = ~clk;

   internet_mux_arbiter_if #(.WIDTH(4)) linkA ();
   internet_mux_arbiter_if #(.WIDTH(4)) linkB ();

   internet_mux_arbiter #(.WIDTH(4), .HOLD_CYCLES(4)) dutA (
      .clk   (clk),
      .reset (reset),
      .link  (linkA)
   );

   internet_mux_arbiter #(.WIDTH(4), .HOLD_CYCLES(1)) dutB (
      .clk   (clk),
      .reset (reset),
      .link  (linkB)
   );

   // Observed bundle is {Enable, Sel, muxOutput, grant}.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] obs, exp;
      reset = 1'b1;
      step();
      step();
      exp = {1'b0, SEL_LIB, 4'h0, 4'b0000};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL reset_A: got %h expected %h", obs, exp);
      else passCount++;
      obs = {linkB.Enable, linkB.Sel, linkB.muxOutput, linkB.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL reset_B: got %h expected %h", obs, exp);
      else passCount++;
      reset = 1'b0;
      linkA.linkReady = 1'b1;
      step();
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL idle_no_req: got %h expected %h", obs, exp);
      else passCount++;
   endtask

   task automatic test_single();
      logic [10:0] obs, exp;
      logic [3:0]  expData;
      linkA.req       = 4'b0001;
      linkA.LibIn     = 4'hA;
      linkA.linkReady = 1'b1;
      expData         = 4'hA;
      for (int k = 0; k < 8; k++) begin
         step();
         exp = {1'b1, SEL_LIB, expData, 4'b0001};
         obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
         checkCount++;
         if (obs !== exp) $display("[TB] FAIL single_beat%0d: got %h expected %h", k, obs, exp);
         else passCount++;
         expData     = 4'(k) + 4'h1;
         linkA.LibIn = expData;
      end
      linkA.req = 4'b0000;
      step();
      exp = {1'b0, SEL_LIB, 4'h0, 4'b0000};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL single_to_idle: got %h expected %h", obs, exp);
      else passCount++;
   endtask

   task automatic test_all_four();
      logic [10:0] obs, exp;
      logic [1:0]  expSel;
      pulseReset();
      linkA.LibIn     = 4'h1;
      linkA.FDIn      = 4'h2;
      linkA.RibsIn    = 4'h3;
      linkA.SchoolIn  = 4'h4;
      linkA.linkReady = 1'b1;
      linkA.req       = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         step();
         expSel = 2'((k / 4) % 4);
         exp = {1'b1, expSel, 4'({2'b00, expSel}) + 4'h1, 4'b0001 << expSel};
         obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
         checkCount++;
         if (obs !== exp) $display("[TB] FAIL all_four_cycle%0d: got %h expected %h", k, obs, exp);
         else passCount++;
      end
      linkA.req = 4'b0000;
   endtask

   task automatic test_stall();
      logic [10:0] obs, exp;
      pulseReset();
      linkA.linkReady = 1'b0;
      linkA.req       = 4'b0010;
      linkA.FDIn      = 4'h5;
      step();
      exp = {1'b1, SEL_FD, 4'h5, 4'b0000};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL stall_load: got %h expected %h", obs, exp);
      else passCount++;
      linkA.FDIn = 4'h6;
      linkA.req  = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         step();
         obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
         checkCount++;
         if (obs !== exp) $display("[TB] FAIL stall_hold%0d: got %h expected %h", k, obs, exp);
         else passCount++;
      end
      linkA.linkReady = 1'b1;
      #1;
      exp = {1'b1, SEL_FD, 4'h5, 4'b0010};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL stall_grant: got %h expected %h", obs, exp);
      else passCount++;
      step();
      exp = {1'b0, SEL_FD, 4'h0, 4'b0000};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL stall_release: got %h expected %h", obs, exp);
      else passCount++;
   endtask

   task automatic test_early_release();
      logic [10:0] obs, exp;
      pulseReset();
      linkA.linkReady = 1'b1;
      linkA.req       = 4'b0100;
      linkA.RibsIn    = 4'h7;
      step();
      linkA.req      = 4'b1100;
      linkA.SchoolIn = 4'h9;
      exp = {1'b1, SEL_RIBS, 4'h7, 4'b0100};
      for (int k = 0; k < 3; k++) begin
         obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
         checkCount++;
         if (obs !== exp) $display("[TB] FAIL early_ribs%0d: got %h expected %h", k, obs, exp);
         else passCount++;
         if (k < 2) step();
      end
      linkA.req = 4'b1000;
      step();
      linkA.req   = 4'b1001;
      linkA.LibIn = 4'h3;
      exp = {1'b1, SEL_SCHOOL, 4'h9, 4'b1000};
      for (int k = 0; k < 4; k++) begin
         obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
         checkCount++;
         if (obs !== exp) $display("[TB] FAIL early_school%0d: got %h expected %h", k, obs, exp);
         else passCount++;
         step();
      end
      exp = {1'b1, SEL_LIB, 4'h3, 4'b0001};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL early_to_lib: got %h expected %h", obs, exp);
      else passCount++;
      linkA.req = 4'b0000;
   endtask

   task automatic test_hold_one();
      logic [10:0] obs, exp;
      linkB.FDIn      = 4'h1;
      linkB.SchoolIn  = 4'h2;
      linkB.linkReady = 1'b1;
      linkB.req       = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         step();
         if (k % 2 == 0) exp = {1'b1, SEL_FD, 4'h1, 4'b0010};
         else            exp = {1'b1, SEL_SCHOOL, 4'h2, 4'b1000};
         obs = {linkB.Enable, linkB.Sel, linkB.muxOutput, linkB.grant};
         checkCount++;
         if (obs !== exp) $display("[TB] FAIL hold_one_cycle%0d: got %h expected %h", k, obs, exp);
         else passCount++;
      end
      linkB.req = 4'b0000;
      step();
      exp = {1'b0, SEL_SCHOOL, 4'h0, 4'b0000};
      obs = {linkB.Enable, linkB.Sel, linkB.muxOutput, linkB.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL hold_one_idle: got %h expected %h", obs, exp);
      else passCount++;
   endtask

   task automatic test_reset_mid();
      logic [10:0] obs, exp;
      pulseReset();
      linkA.linkReady = 1'b1;
      linkA.req       = 4'b1000;
      linkA.SchoolIn  = 4'hC;
      step();
      step();
      step();
      exp = {1'b1, SEL_SCHOOL, 4'hC, 4'b1000};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL mid_school: got %h expected %h", obs, exp);
      else passCount++;
      linkA.req    = 4'b1111;
      linkA.LibIn  = 4'h4;
      linkA.FDIn   = 4'h5;
      linkA.RibsIn = 4'h6;
      reset        = 1'b1;
      step();
      exp = {1'b0, SEL_LIB, 4'h0, 4'b0000};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL mid_reset: got %h expected %h", obs, exp);
      else passCount++;
      reset = 1'b0;
      step();
      exp = {1'b1, SEL_LIB, 4'h4, 4'b0001};
      obs = {linkA.Enable, linkA.Sel, linkA.muxOutput, linkA.grant};
      checkCount++;
      if (obs !== exp) $display("[TB] FAIL mid_lib_first: got %h expected %h", obs, exp);
      else passCount++;
   endtask

   initial begin
      reset           = 1'b1;
      linkA.LibIn     = '0;
      linkA.FDIn      = '0;
      linkA.RibsIn    = '0;
      linkA.SchoolIn  = '0;
      linkA.req       = '0;
      linkA.linkReady = 1'b0;
      linkB.LibIn     = '0;
      linkB.FDIn      = '0;
      linkB.RibsIn    = '0;
      linkB.SchoolIn  = '0;
      linkB.req       = '0;
      linkB.linkReady = 1'b0;
      #2;
      test_reset();
      test_single();
      test_all_four();
      test_stall();
      test_early_release();
      test_hold_one();
      test_reset_mid();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/internet_mux_arbiter.md
# internet_mux_arbiter

Source-side counterpart of the internet routing demux. It collects 4-bit words from the four endpoints (Lib, FD, Ribs, School) and arbitrates them round-robin onto one shared link. Each beat is presented as `muxOutput` / `Sel` / `Enable`, with the same encoding the demux decodes. Beats are flow-controlled by a downstream `linkReady`, and each owner's tenure is capped at `HOLD_CYCLES` beats.

## Interface
- `WIDTH`, default 4: data width per endpoint and on the link.
- `HOLD_CYCLES`, default 4: maximum accepted beats per grant; legal range 1–15.
- `clk`  input  1: single clock; all state updates on rising edge.
- `reset`  input  1: synchronous, active-high.
- `LibIn`, `FDIn`, `RibsIn`, `SchoolIn`  input  WIDTH each: endpoint data, valid while the matching `req` bit is high.
- `req`  input  4: request per endpoint; bit index equals Sel code (0 Lib, 1 FD, 2 Ribs, 3 School).
- `linkReady`  input  1: downstream accepts the current beat this cycle.
- `grant`  output  4: one-hot; `grant[i]` = `Enable & linkReady & (Sel==i)`. Endpoint i advances its data on this.
- `muxOutput`  output  WIDTH: registered link data.
- `Sel`  output  2: registered endpoint code: Lib 00, FD 01, Ribs 10, School 11.
- `Enable`  output  1: registered beat-valid.

## Operation
- States: IDLE, GRANT.
- Registers: `owner` (2b), `last` (2b, most recent owner), `cnt` (4b, accepted beats this tenure), outputs.
- **Pick rule.** Search `req` starting at `last+1` mod 4, wrapping, with `last` itself checked last. The first set bit wins.
- **IDLE.**
  - Any `req`: go to GRANT. Load `owner`/`Sel` with the winner, `Enable`←1, `muxOutput`←winner's data, `cnt`←0.
  - No `req`: stay IDLE with `Enable`=0, `muxOutput`=0.
- **GRANT, `linkReady`=0 (stall).** All outputs and state hold, even if `req[owner]` drops. A presented beat is never withdrawn or altered.
- **GRANT, `linkReady`=1 (beat accepted).**
  - **Continue:** if `req[owner]`=1 and `cnt+1 < HOLD_CYCLES`, stay with the same owner, `cnt`++, `muxOutput`←owner's (new) data.
  - **Release:** otherwise `last`←`owner` and re-run the pick rule on the current `req`, with no idle bubble. A winner loads as in IDLE with `cnt`←0. If the owner is the only requester it may win again.
  - **Release, no requests:** if no `req` is set, go to IDLE with `Enable`←0, `muxOutput`←0, and `Sel` holding its last value.
- **Width rules.**
  - The `cnt+1` compare uses 5 bits, so it never wraps.
  - `HOLD_CYCLES`=1 forces a release after every beat.

## Timing
- **Reset values:** state IDLE, `Enable` 0, `muxOutput` 0, `Sel` 00, `owner` 00, `last` 11 (so Lib has first priority), `cnt` 0, `grant` 0000.
- **Request latency:** `req` rising in IDLE at edge N gives `Enable`=1 after edge N+1.
- **Handover:** back-to-back owners need zero idle cycles.
- **Beat acceptance:** exactly the cycles with `Enable & linkReady`. `grant` is combinational from registered outputs plus `linkReady`, and never asserts while `Enable`=0.
- **Reset mid-tenure:** wins over all other inputs. The next cycle shows reset values, and the pending beat is dropped.
- **Endpoint data:** sampled only on the edge that loads `muxOutput`; changes at other times are ignored.

## Structure
- **Package `internet_pkg`:**
  - Sel codes `SEL_LIB`=2'b00, `SEL_FD`=2'b01, `SEL_RIBS`=2'b10, `SEL_SCHOOL`=2'b11.
  - State enum {IDLE, GRANT}.
  - Shared with the demux.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs `req[3:0]`, `last[1:0]`; outputs `any`, `win[1:0]`. It is instantiated once and used in both IDLE and release.
- **Top level:** holds the FSM, the counter, and the registered output stage.

## Test plan
- **Reset then single request:** `req`=0001, `LibIn`=4'hA, `linkReady`=1. Expect `Enable`=1, `Sel`=00, `muxOutput`=A on the second cycle after the request. `grant`=0001 each accepted cycle; tenure ends after 4 beats, after which Lib is re-granted with no bubble.
- **All four requesting, `linkReady`=1, HOLD=4:** tenure order Lib, FD, Ribs, School, each exactly 4 beats, then Lib again. Contiguous `Enable` throughout.
- **Stall:** FD owns with `muxOutput`=4'h5, `linkReady`=0 for 3 cycles while `FDIn` changes to 4'h6 and `req[1]` drops. Outputs hold 5/01/1 and `grant`=0000. When `linkReady` rises, 1 beat is accepted and the arbiter releases.
- **Early release:** Ribs owns, drops `req[2]` after its 2nd accepted beat, School requesting. School loads on the next edge with `cnt`=0.
- **HOLD_CYCLES=1, `req`=1010:** alternating FD and School every cycle with no gaps.
- **Reset asserted mid-GRANT (School, `cnt`=2):** next cycle `Enable`=0, `muxOutput`=0, `Sel`=00. After reset release with all requesting, Lib wins first.
